// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the 64-bit word-indexed data memory.
// Ports: req_* (load/store request, valid/ready), resp_* (response,
// valid/ready), mem_* (word address, merged write data, write strobe,
// combinational read data). Sub-word stores are read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: reject misaligned requests with
// resp_error instead of force-aligning them.
module load_store_unit #(
    parameter int WORDSIZE = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [2:0]          req_funct3,
    input  logic [WORDSIZE-1:0] req_addr,
    input  logic [WORDSIZE-1:0] req_wdata,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [WORDSIZE-1:0] resp_rdata,
    output logic                resp_error,
    output logic [WORDSIZE-1:0] mem_addr,
    output logic [WORDSIZE-1:0] mem_wdata,
    output logic                mem_write_en,
    input  logic [WORDSIZE-1:0] mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

    state_t              state_q, state_d;
    logic                write_q, write_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [2:0]          off_q, off_d;
    logic [WORDSIZE-1:0] wdata_q, wdata_d;
    logic                req_ready_q, req_ready_d;
    logic                resp_valid_q, resp_valid_d;
    logic [WORDSIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic                resp_error_q, resp_error_d;
    logic [WORDSIZE-1:0] mem_addr_q, mem_addr_d;
    logic [WORDSIZE-1:0] mem_wdata_q, mem_wdata_d;
    logic                mem_write_en_q, mem_write_en_d;

    // Access size minus one, in bytes: 0, 1, 3 or 7.
    function automatic logic [2:0] size_m1(input logic [1:0] sz);
        logic [2:0] m;
        unique case (sz)
            2'd0:    m = 3'd0;
            2'd1:    m = 3'd1;
            2'd2:    m = 3'd3;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

    logic [2:0]          req_m1;
    logic                req_misal;
    logic                req_illegal;
    logic                req_err;
    logic [2:0]          cur_m1;
    logic [WORDSIZE-1:0] rd_shift;
    logic [WORDSIZE-1:0] wd_shift;
    logic [WORDSIZE-1:0] rd_ext;
    logic [WORDSIZE-1:0] merged;
    logic [3:0]          lane_lo;
    logic [3:0]          lane_hi;

    always_comb begin
        req_m1      = size_m1(req_funct3[1:0]);
        req_misal   = |(req_addr[2:0] & req_m1);
        // Loads reject only 111; stores reject every unsigned code too.
        req_illegal = (req_funct3 == 3'b111) || (req_write && req_funct3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
        req_err     = req_illegal || req_misal;
`else
        req_err     = req_illegal;
`endif
    end

    always_comb begin
        cur_m1   = size_m1(funct3_q[1:0]);
        rd_shift = mem_rdata >> {off_q, 3'b000};
        wd_shift = wdata_q << {off_q, 3'b000};
        rd_ext   = '0;
        unique case (funct3_q)
            3'b000:  rd_ext = {{(WORDSIZE-8){rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  rd_ext = {{(WORDSIZE-16){rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  rd_ext = {{(WORDSIZE-32){rd_shift[31]}}, rd_shift[31:0]};
            3'b011:  rd_ext = rd_shift;
            3'b100:  rd_ext = {{(WORDSIZE-8){1'b0}}, rd_shift[7:0]};
            3'b101:  rd_ext = {{(WORDSIZE-16){1'b0}}, rd_shift[15:0]};
            3'b110:  rd_ext = {{(WORDSIZE-32){1'b0}}, rd_shift[31:0]};
            default: rd_ext = '0;
        endcase
        // Replace lanes off..off+size-1; off is already size-aligned.
        lane_lo = {1'b0, off_q};
        lane_hi = {1'b0, off_q} + {1'b0, cur_m1};
        merged  = mem_rdata;
        for (int k = 0; k < 8; k++) begin
            if (4'(k) >= lane_lo && 4'(k) <= lane_hi) begin
                merged[8*k +: 8] = wd_shift[8*k +: 8];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        write_d        = write_q;
        funct3_d       = funct3_q;
        off_d          = off_q;
        wdata_d        = wdata_q;
        req_ready_d    = req_ready_q;
        resp_valid_d   = resp_valid_q;
        resp_rdata_d   = resp_rdata_q;
        resp_error_d   = resp_error_q;
        mem_addr_d     = mem_addr_q;
        mem_wdata_d    = mem_wdata_q;
        mem_write_en_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    write_d     = req_write;
                    funct3_d    = req_funct3;
                    off_d       = req_addr[2:0] & ~req_m1;
                    wdata_d     = req_wdata;
                    mem_addr_d  = req_addr >> 3;
                    req_ready_d = 1'b0;
                    if (req_err) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_error_d = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                if (write_q) begin
                    mem_wdata_d    = merged;
                    mem_write_en_d = 1'b1;
                    state_d        = WRITE;
                end else begin
                    resp_rdata_d = rd_ext;
                    resp_valid_d = 1'b1;
                    state_d      = RESP;
                end
            end
            WRITE: begin
                resp_rdata_d = '0;
                resp_valid_d = 1'b1;
                state_d      = RESP;
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    resp_error_d = 1'b0;
                    req_ready_d  = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            write_q        <= 1'b0;
            funct3_q       <= 3'b000;
            off_q          <= 3'b000;
            wdata_q        <= '0;
            req_ready_q    <= 1'b1;
            resp_valid_q   <= 1'b0;
            resp_rdata_q   <= '0;
            resp_error_q   <= 1'b0;
            mem_addr_q     <= '0;
            mem_wdata_q    <= '0;
            mem_write_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            write_q        <= write_d;
            funct3_q       <= funct3_d;
            off_q          <= off_d;
            wdata_q        <= wdata_d;
            req_ready_q    <= req_ready_d;
            resp_valid_q   <= resp_valid_d;
            resp_rdata_q   <= resp_rdata_d;
            resp_error_q   <= resp_error_d;
            mem_addr_q     <= mem_addr_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_write_en_q <= mem_write_en_d;
        end
    end

    assign req_ready    = req_ready_q;
    assign resp_valid   = resp_valid_q;
    assign resp_rdata   = resp_rdata_q;
    assign resp_error   = resp_error_q;
    assign mem_addr     = mem_addr_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_write_en = mem_write_en_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the processor data-memory interface. It accepts RISC-V load/store requests carrying a byte address and funct3 size code, and drives the word-indexed, 64-bit data memory. That memory has a combinational read and a write on the rising edge. Sub-word stores are done as read-modify-write, and loads return sign- or zero-extended data through a valid/ready response handshake.

Parameters:
WORDSIZE, 64, data word and address width; the byte lane logic is fixed at 8 lanes, so only 64 is supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, synchronous, active-high
req_valid  input  1  request present
req_ready  output  1  unit can accept a request (high only in IDLE)
req_write  input  1  1 = store, 0 = load
req_funct3  input  3  RISC-V funct3 size/sign code
req_addr  input  WORDSIZE  byte address
req_wdata  input  WORDSIZE  store data, right-aligned
resp_valid  output  1  response present
resp_ready  input  1  consumer accepts response
resp_rdata  output  WORDSIZE  extended load data (0 for stores and errors)
resp_error  output  1  request rejected, no memory access made
mem_addr  output  WORDSIZE  word index = byte address >> 3
mem_wdata  output  WORDSIZE  merged store word
mem_write_en  output  1  memory write strobe
mem_rdata  input  WORDSIZE  memory read data, combinational from mem_addr

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous and active-high.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_addr=0, mem_wdata=0, mem_write_en=0.
- Request acceptance: a request is accepted on an edge where req_valid&&req_ready is true. On that edge the unit latches write, funct3, addr and wdata, and mem_addr <= req_addr>>3.
- funct3 codes: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU.
- Legal codes: loads accept all codes except 111; stores accept 000-011 only.
- Illegal code: goes IDLE->RESP directly with resp_error=1 and rdata=0; no memory access.
- Byte order: little-endian. Byte offset off = addr[2:0]; lane k = bits 8k+7:8k.
- States:
  - IDLE: req_ready=1. On accept, go to ACCESS.
  - ACCESS (1 cycle): mem_addr held; mem_rdata sampled at the end of the cycle.
    - Load: resp_rdata <= the selected field, sign-extended for B/H/W/D or zero-extended for BU/HU/WU; go to RESP.
    - Store: mem_wdata <= mem_rdata with lanes off..off+size-1 replaced by the low size bytes of wdata; go to WRITE. D also goes through ACCESS, so latency is uniform.
  - WRITE (1 cycle): mem_write_en=1, with mem_addr and mem_wdata stable. The memory commits at the closing edge. Go to RESP.
  - RESP: resp_valid=1 and outputs are held stable until resp_valid&&resp_ready. On that edge go to IDLE and clear resp_valid and resp_error; req_ready is high the next cycle.
- Output decode: mem_write_en is a state decode and is never high outside WRITE.
- Latency from the accept edge: load response visible after 2 edges; store after 3. The memory write is exactly one cycle per store.
- Throughput: one outstanding request; there is no pipelining and no request buffering.
- Misalignment without the macro: a request with off not a multiple of its size is force-aligned (off &= ~(size-1)) and then completes normally.
- Reset during a WRITE cycle: the write at that edge still occurs, because mem_write_en was high during the cycle. The unit then returns to IDLE with reset values and produces no response.
- Reset in any other state: no memory write; the unit returns to IDLE.
- rst has priority over every handshake on the same edge.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined: a misaligned request (off mod size ≠ 0) is rejected at accept. The unit goes IDLE->RESP with resp_error=1 and resp_rdata=0; there is no ACCESS and no WRITE.
- Undefined: misaligned addresses are force-aligned as above, and resp_error is raised only for illegal funct3.

Test Plan:
- Reset check: hold rst for 2 cycles -> req_ready=1, resp_valid=0, mem_write_en=0, mem_addr=0, resp_rdata=0.
- Load extension: mem word 0 = 0x00000000800000F0.
  - LB addr 0 -> 0xFFFFFFFFFFFFFFF0.
  - LBU -> 0xF0.
  - LW -> 0xFFFFFFFF800000F0.
  - LWU -> 0x00000000800000F0.
  - Each response arrives 2 edges after accept.
- Sub-word store: mem word 1 = 0x1122334455667788; SH addr 0x0A, wdata 0xABCD.
  - mem_addr=1 and mem_write_en high for exactly 1 cycle.
  - Word becomes 0x11223344ABCD7788.
  - resp_valid appears 3 edges after accept with rdata=0.
- Backpressure: issue a load with resp_ready=0 for 3 cycles -> resp_valid, resp_rdata and req_ready=0 held stable. Raise resp_ready -> IDLE, req_ready=1 next cycle. A req_valid held during RESP is not accepted.
- Misalignment: LW addr 0x2.
  - With the macro: resp_error=1, rdata=0, no ACCESS.
  - Without the macro: returns word 0 bits 31:0, extended.
  - Load with funct3 111 -> resp_error=1 either way.
- Reset in WRITE: assert rst during the WRITE cycle of an SB -> the memory byte is updated, the unit is in IDLE next cycle, and resp_valid never rises.
